// File: rtl/fp_core_arbiter_pkg.sv
// Shared definitions for the fp_core arbiter and the scalar-multiplication units:
// core select codes, opcode/state enums and the P-256 field constants.
package fp_core_arbiter_pkg;

   localparam logic [2:0] SEL_IDLE = 3'b000;
   localparam logic [2:0] SEL_MM   = 3'b100;
   localparam logic [2:0] SEL_AS   = 3'b010;

   typedef enum logic {
      OP_MM = 1'b0,
      OP_AS = 1'b1
   } op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   // NIST P-256 prime and R^2 mod p for R = 2^256 (Montgomery domain entry)
   localparam logic [255:0] FIELD_P  =
      256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;
   localparam logic [255:0] FIELD_R2 =
      256'h00000004_FFFFFFFD_FFFFFFFF_FFFFFFFE_FFFFFFFB_FFFFFFFF_00000000_00000003;

endpackage

// File: rtl/fp_core_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] win,
   output logic [IW-1:0]   idx
);

   logic        found;
   int unsigned k;
   logic [IW-1:0] k_idx;

   always_comb begin
      win   = '0;
      idx   = '0;
      found = 1'b0;
      k     = 0;
      k_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k     = (32'(ptr) + i) % NREQ;
         k_idx = IW'(k);
         if (!found && req[k_idx]) begin
            found      = 1'b1;
            win[k_idx] = 1'b1;
            idx        = k_idx;
         end
      end
   end

endmodule

// File: rtl/fp_core_arbiter.sv
// Round-robin arbiter sharing one fp_core (Montgomery multiply / modular add-sub)
// among NREQ requesters, with multiply timeout and completion pulses.
module fp_core_arbiter
   import fp_core_arbiter_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int W       = 256,
   parameter int ADD_LAT = 2,
   parameter int TMO     = 1023
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic [NREQ-1:0]     req,
   input  logic [NREQ-1:0]     op,
   input  logic [NREQ*W-1:0]   a_in,
   input  logic [NREQ*W-1:0]   b_in,
   output logic [NREQ-1:0]     gnt,
   output logic [NREQ-1:0]     done,
   output logic [W-1:0]        res,
   output logic                err,
   output logic [2:0]          core_sel,
   output logic [W-1:0]        core_a,
   output logic [W-1:0]        core_b,
   input  logic [W-1:0]        core_mm,
   input  logic                core_end,
   input  logic [W-1:0]        core_as
);

   localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CMAX = (TMO > ADD_LAT) ? TMO : ADD_LAT;
   localparam int CW   = $clog2(CMAX + 1);

   state_t          state, state_nxt;
   logic [IW-1:0]   ptr, owner;
   op_t             op_q;
   logic [CW-1:0]   cnt;
   logic            tmo_q;

   logic [NREQ-1:0] win;
   logic [IW-1:0]   win_idx;
   logic [W-1:0]    a_arr [NREQ];
   logic [W-1:0]    b_arr [NREQ];
   logic            mm_end, add_end, tmo_hit;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign a_arr[g] = a_in[g*W +: W];
      assign b_arr[g] = b_in[g*W +: W];
   end

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .req (req),
      .ptr (ptr),
      .win (win),
      .idx (win_idx)
   );

   // Timeout fires on the cycle cnt would step to TMO, so DONE lands TMO+1 cycles after ISSUE
   always_comb begin
      mm_end  = (op_q == OP_MM) && core_end;
      add_end = (op_q == OP_AS) && (cnt == CW'(ADD_LAT - 1));
      tmo_hit = (op_q == OP_MM) && !core_end && (cnt == CW'(TMO - 1));
   end

   always_ff @(posedge clk) begin
      if (rst_b) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = '0;
      err       = 1'b0;
      case (state)
         IDLE:  if (|req) state_nxt = ISSUE;
         ISSUE: state_nxt = WAIT;
         WAIT:  if (mm_end || add_end || tmo_hit) state_nxt = DONE;
         DONE: begin
            state_nxt   = IDLE;
            done[owner] = req[owner];
            err         = tmo_q;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         ptr      <= '0;
         owner    <= '0;
         op_q     <= OP_MM;
         cnt      <= '0;
         tmo_q    <= 1'b0;
         gnt      <= '0;
         res      <= '0;
         core_sel <= SEL_IDLE;
         core_a   <= '0;
         core_b   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|req) begin
                  owner    <= win_idx;
                  gnt      <= win;
                  core_a   <= a_arr[win_idx];
                  core_b   <= b_arr[win_idx];
                  op_q     <= op_t'(op[win_idx]);
                  core_sel <= op[win_idx] ? SEL_AS : SEL_MM;
                  tmo_q    <= 1'b0;
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               if (mm_end || add_end || tmo_hit) begin
                  gnt      <= '0;
                  core_sel <= SEL_IDLE;
                  tmo_q    <= tmo_hit;
                  if (mm_end)       res <= core_mm;
                  else if (add_end) res <= core_as;
                  else              res <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_core_arbiter.sv
// Directed self-checking bench for fp_core_arbiter with a hand-driven core model.
module tb_fp_core_arbiter;

   localparam int NREQ    = 4;
   localparam int W       = 256;
   localparam int ADD_LAT = 2;
   localparam int TMO     = 1023;

   logic              clk = 1'b0;
   logic              rst_b;
   logic [NREQ-1:0]   req, op;
   logic [NREQ*W-1:0] a_in, b_in;
   logic [NREQ-1:0]   gnt, done;
   logic [W-1:0]      res;
   logic              err;
   logic [2:0]        core_sel;
   logic [W-1:0]      core_a, core_b;
   logic [W-1:0]      core_mm, core_as;
   logic              core_end;

   int pass_cnt = 0;
   int total    = 0;

   fp_core_arbiter #(
      .NREQ    (NREQ),
      .W       (W),
      .ADD_LAT (ADD_LAT),
      .TMO     (TMO)
   ) dut (
      .clk      (clk),
      .rst_b    (rst_b),
      .req      (req),
      .op       (op),
      .a_in     (a_in),
      .b_in     (b_in),
      .gnt      (gnt),
      .done     (done),
      .res      (res),
      .err      (err),
      .core_sel (core_sel),
      .core_a   (core_a),
      .core_b   (core_b),
      .core_mm  (core_mm),
      .core_end (core_end),
      .core_as  (core_as)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int gnt_idx(input logic [NREQ-1:0] g);
      int r = -1;
      for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
      return r;
   endfunction

   task automatic test_reset();
      rst_b = 1'b1;
      step();
      step();
      total += 7;
      if (gnt !== '0)      $display("FAIL reset_gnt got=%b want=0", gnt);           else pass_cnt++;
      if (done !== '0)     $display("FAIL reset_done got=%b want=0", done);         else pass_cnt++;
      if (err !== 1'b0)    $display("FAIL reset_err got=%b want=0", err);           else pass_cnt++;
      if (res !== '0)      $display("FAIL reset_res got=%h want=0", res);           else pass_cnt++;
      if (core_sel !== 3'b000) $display("FAIL reset_sel got=%b want=000", core_sel); else pass_cnt++;
      if (core_a !== '0)   $display("FAIL reset_core_a got=%h want=0", core_a);     else pass_cnt++;
      if (core_b !== '0)   $display("FAIL reset_core_b got=%h want=0", core_b);     else pass_cnt++;
      rst_b = 1'b0;
   endtask

   task automatic test_contention();
      int   exp_order[5] = '{0, 1, 2, 3, 0};
      int   n = 0, gap = 0, dones = 0;
      logic [NREQ-1:0] prev = '0;
      bit   bad1h = 0, bad_res = 0;
      req     = '1;
      op      = '1;
      core_as = W'(32'hA5A5_0001);
      for (int c = 0; c < 100 && n < 5; c++) begin
         step();
         if (!$onehot0(gnt)) bad1h = 1;
         if (done !== '0) begin
            dones++;
            if (res !== core_as) bad_res = 1;
         end
         if (gnt !== '0 && prev === '0) begin
            total++;
            if (gnt_idx(gnt) !== exp_order[n])
               $display("FAIL rr_order grant#%0d got=%0d want=%0d", n, gnt_idx(gnt), exp_order[n]);
            else pass_cnt++;
            if (n > 0) begin
               total++;
               if (gap !== 2) $display("FAIL rr_gap grant#%0d got=%0d want=2", n, gap);
               else pass_cnt++;
            end
            n++;
            gap = 0;
         end else if (gnt === '0) begin
            gap++;
         end
         prev = gnt;
      end
      req = '0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (!$onehot0(gnt)) bad1h = 1;
         if (done !== '0) dones++;
      end
      total += 4;
      if (n !== 5)     $display("FAIL rr_grants got=%0d want=5", n);         else pass_cnt++;
      if (dones !== 4) $display("FAIL rr_dones got=%0d want=4", dones);      else pass_cnt++;
      if (bad1h)       $display("FAIL rr_onehot got=1 want=0");              else pass_cnt++;
      if (bad_res)     $display("FAIL rr_res got=bad want=%h", core_as);     else pass_cnt++;
   endtask

   task automatic test_mult();
      bit early = 0, bad_sel = 0;
      a_in = '0;
      b_in = '0;
      a_in[0 +: W] = W'(3);
      b_in[0 +: W] = W'(5);
      op       = 4'b0000;
      core_mm  = W'(8'h0F);
      core_end = 1'b0;
      req      = 4'b0001;
      step();
      total += 4;
      if (gnt !== 4'b0001)     $display("FAIL mm_gnt got=%b want=0001", gnt);       else pass_cnt++;
      if (core_sel !== 3'b100) $display("FAIL mm_sel got=%b want=100", core_sel);   else pass_cnt++;
      if (core_a !== W'(3))    $display("FAIL mm_core_a got=%h want=3", core_a);    else pass_cnt++;
      if (core_b !== W'(5))    $display("FAIL mm_core_b got=%h want=5", core_b);    else pass_cnt++;
      core_end = 1'b1;   // stale end during ISSUE must be ignored
      step();
      core_end = 1'b0;
      a_in[0 +: W] = W'(7);
      for (int i = 0; i < 9; i++) begin
         step();
         if (done !== '0) early = 1;
         if (core_sel !== 3'b100) bad_sel = 1;
      end
      core_end = 1'b1;
      step();
      total += 6;
      if (early)            $display("FAIL mm_early_done got=1 want=0");          else pass_cnt++;
      if (bad_sel)          $display("FAIL mm_sel_hold got=unstable want=100");   else pass_cnt++;
      if (done !== 4'b0001) $display("FAIL mm_done got=%b want=0001", done);      else pass_cnt++;
      if (res !== W'(8'h0F)) $display("FAIL mm_res got=%h want=0f", res);         else pass_cnt++;
      if (err !== 1'b0)     $display("FAIL mm_err got=%b want=0", err);           else pass_cnt++;
      if (core_a !== W'(3)) $display("FAIL mm_latch got=%h want=3", core_a);      else pass_cnt++;
      core_end = 1'b0;
      step();
      total++;
      if (done !== '0) $display("FAIL mm_done_pulse got=%b want=0", done); else pass_cnt++;
      req = '0;
      step();
      total++;
      if (dut.ptr !== 2'd1) $display("FAIL mm_ptr got=%0d want=1", dut.ptr); else pass_cnt++;
   endtask

   task automatic test_add();
      logic [2:0]      sel_seq  [4] = '{3'b010, 3'b010, 3'b010, 3'b000};
      logic [NREQ-1:0] done_seq [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100};
      op      = 4'b0100;
      core_as = W'(16'h1234);
      total++;
      if (core_sel !== 3'b000) $display("FAIL add_sel_idle got=%b want=000", core_sel); else pass_cnt++;
      req = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         step();
         total += 2;
         if (core_sel !== sel_seq[i])
            $display("FAIL add_sel cyc%0d got=%b want=%b", i, core_sel, sel_seq[i]);
         else pass_cnt++;
         if (done !== done_seq[i])
            $display("FAIL add_done cyc%0d got=%b want=%b", i, done, done_seq[i]);
         else pass_cnt++;
      end
      total++;
      if (res !== W'(16'h1234)) $display("FAIL add_res got=%h want=1234", res); else pass_cnt++;
      req = '0;
      step();
      total++;
      if (dut.ptr !== 2'd3) $display("FAIL add_ptr got=%0d want=3", dut.ptr); else pass_cnt++;
   endtask

   task automatic test_drop();
      bit seen = 0;
      op       = 4'b0000;
      core_end = 1'b0;
      req      = 4'b0010;
      step();
      total++;
      if (gnt !== 4'b0010) $display("FAIL drop_gnt got=%b want=0010", gnt); else pass_cnt++;
      step();
      step();
      req = '0;
      step();
      step();
      core_end = 1'b1;
      step();
      if (done !== '0) seen = 1;
      total += 2;
      if (gnt !== '0)   $display("FAIL drop_gnt_clr got=%b want=0", gnt); else pass_cnt++;
      if (err !== 1'b0) $display("FAIL drop_err got=%b want=0", err);     else pass_cnt++;
      core_end = 1'b0;
      step();
      if (done !== '0) seen = 1;
      step();
      total += 3;
      if (seen)             $display("FAIL drop_done got=1 want=0");               else pass_cnt++;
      if (gnt !== '0)       $display("FAIL drop_idle_gnt got=%b want=0", gnt);     else pass_cnt++;
      if (dut.ptr !== 2'd2) $display("FAIL drop_ptr got=%0d want=2", dut.ptr);     else pass_cnt++;
   endtask

   task automatic test_midreset();
      bit seen3 = 0;
      op = 4'b0000;
      a_in[3*W +: W] = W'(32'hDEAD);
      core_end = 1'b0;
      core_as  = W'(8'h77);
      req = 4'b1000;
      step();
      total++;
      if (gnt !== 4'b1000) $display("FAIL mrst_gnt got=%b want=1000", gnt); else pass_cnt++;
      step();
      step();
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
      total += 7;
      if (gnt !== '0)          $display("FAIL mrst_gnt_clr got=%b want=0", gnt);     else pass_cnt++;
      if (done !== '0)         $display("FAIL mrst_done got=%b want=0", done);       else pass_cnt++;
      if (err !== 1'b0)        $display("FAIL mrst_err got=%b want=0", err);         else pass_cnt++;
      if (res !== '0)          $display("FAIL mrst_res got=%h want=0", res);         else pass_cnt++;
      if (core_sel !== 3'b000) $display("FAIL mrst_sel got=%b want=000", core_sel); else pass_cnt++;
      if (core_a !== '0)       $display("FAIL mrst_core_a got=%h want=0", core_a);   else pass_cnt++;
      if (core_b !== '0)       $display("FAIL mrst_core_b got=%h want=0", core_b);   else pass_cnt++;
      req = 4'b1010;
      op  = 4'b0010;
      step();
      total++;
      if (gnt !== 4'b0010) $display("FAIL mrst_first_gnt got=%b want=0010", gnt); else pass_cnt++;
      step();
      step();
      step();
      total += 2;
      if (done !== 4'b0010)   $display("FAIL mrst_add_done got=%b want=0010", done); else pass_cnt++;
      if (res !== W'(8'h77))  $display("FAIL mrst_add_res got=%h want=77", res);     else pass_cnt++;
      req = '0;
      step();
      if (done[3]) seen3 = 1;
      step();
      total++;
      if (seen3) $display("FAIL mrst_dropped_done got=1 want=0"); else pass_cnt++;
   endtask

   task automatic test_timeout();
      bit early = 0;
      op       = 4'b0000;
      core_end = 1'b0;
      req      = 4'b0001;
      step();
      total++;
      if (gnt !== 4'b0001) $display("FAIL tmo_gnt got=%b want=0001", gnt); else pass_cnt++;
      for (int i = 1; i <= TMO; i++) begin
         step();
         if (done !== '0 || err !== 1'b0) early = 1;
      end
      step();
      total += 4;
      if (early)            $display("FAIL tmo_early got=1 want=0");              else pass_cnt++;
      if (err !== 1'b1)     $display("FAIL tmo_err got=%b want=1", err);          else pass_cnt++;
      if (done !== 4'b0001) $display("FAIL tmo_done got=%b want=0001", done);     else pass_cnt++;
      if (res !== '0)       $display("FAIL tmo_res got=%h want=0", res);          else pass_cnt++;
      step();
      total++;
      if (err !== 1'b0 || done !== '0)
         $display("FAIL tmo_pulse got=err%b/done%b want=0/0", err, done);
      else pass_cnt++;
      req = '0;
      step();
   endtask

   initial begin
      rst_b    = 1'b1;
      req      = '0;
      op       = '0;
      a_in     = '0;
      b_in     = '0;
      core_mm  = '0;
      core_as  = '0;
      core_end = 1'b0;
      test_reset();
      test_contention();
      test_mult();
      test_add();
      test_drop();
      test_midreset();
      test_timeout();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
